// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   BYTE_W    : width of one stream byte.
//   WORD_W    : width of one instruction word and of the byte address.
//   ADDR_STEP : address increment per word, matching the CPU's PC+2.
//   state_e   : loader FSM states.
package instr_loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned ADDR_STEP = 2;

    typedef enum logic [3:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDatHi,
        StDatLo,
        StWrite,
        StChk,
        StDone,
        StError
    } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Stream and instruction-memory bus of the loader.
//   in_data/in_valid/in_ready : byte stream, transfer when valid & ready.
//   imem_we/imem_addr/imem_wdata : instruction memory write port.
// Modport slave is the loader side; master is the stream source / memory side.
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/instr_loader.sv
// Boot-time writer for the 16-bit instruction memory.
// Receives LEN_HI, LEN_LO, N x (W_HI, W_LO), CHK over a byte stream, writes the
// big-endian words to consecutive even byte addresses from BASE_ADDR, checks the
// XOR checksum and releases the CPU from reset only after a good load.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset.
//   start        : begins a load; sampled in IDLE, DONE and ERROR only.
//   bus          : stream input and instruction-memory write port.
//   cpu_reset    : 1 holds the CPU in reset.
//   busy         : load in progress.
//   done, error  : outcome of the last load.
//   words_loaded : words written in the current or last load.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000,
    parameter int unsigned       MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_loader_if.slave     bus,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [WORD_W-1:0] words_loaded
);

    localparam logic [WORD_W-1:0] MAX_LEN = WORD_W'(MAX_WORDS);

    state_e            state;
    logic [WORD_W-1:0] len;
    logic [BYTE_W-1:0] hi_byte;
    logic [BYTE_W-1:0] checksum;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] len_full;
    logic [WORD_W-1:0] words_inc;

    // Full length as it will be once the low byte lands this edge.
    assign len_full  = {len[WORD_W-1:BYTE_W], bus.in_data};
    assign words_inc = words_loaded + WORD_W'(1);

    assign bus.in_ready   = state inside {StLenHi, StLenLo, StDatHi, StDatLo, StChk};
    assign bus.imem_we    = (state == StWrite);
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = wdata;
    assign busy           = !(state inside {StIdle, StDone, StError});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
            addr         <= BASE_ADDR;
            wdata        <= '0;
            len          <= '0;
            hi_byte      <= '0;
        end else begin
            unique case (state)
                StIdle, StDone, StError: begin
                    if (start) begin
                        state        <= StLenHi;
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        checksum     <= '0;
                        addr         <= BASE_ADDR;
                    end
                end
                StLenHi: begin
                    if (bus.in_valid) begin
                        len[WORD_W-1:BYTE_W] <= bus.in_data;
                        checksum             <= checksum ^ bus.in_data;
                        state                <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (bus.in_valid) begin
                        len[BYTE_W-1:0] <= bus.in_data;
                        checksum        <= checksum ^ bus.in_data;
                        if (len_full == '0) begin
                            state <= StChk;
                        end else if (len_full > MAX_LEN) begin
                            state <= StError;
                            error <= 1'b1;
                        end else begin
                            state <= StDatHi;
                        end
                    end
                end
                StDatHi: begin
                    if (bus.in_valid) begin
                        hi_byte  <= bus.in_data;
                        checksum <= checksum ^ bus.in_data;
                        state    <= StDatLo;
                    end
                end
                StDatLo: begin
                    if (bus.in_valid) begin
                        wdata    <= {hi_byte, bus.in_data};
                        checksum <= checksum ^ bus.in_data;
                        state    <= StWrite;
                    end
                end
                StWrite: begin
                    // imem_we is high for this single cycle only.
                    words_loaded <= words_inc;
                    addr         <= addr + WORD_W'(ADDR_STEP);
                    state        <= (words_inc < len) ? StDatHi : StChk;
                end
                StChk: begin
                    if (bus.in_valid) begin
                        if (bus.in_data == checksum) begin
                            state     <= StDone;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= StError;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    instr_loader_if bus ();

    instr_loader #(
        .BASE_ADDR (16'h0000),
        .MAX_WORDS (256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  stream[$];
    int          checks   = 0;
    int          failures = 0;
    int          wr_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe pops one expected write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_t e;
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {16'h0, bus.imem_addr}, {16'h0, e.addr});
                check("wr_data", {16'h0, bus.imem_wdata}, {16'h0, e.data});
            end
        end
    end

    task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required 1 (byte %h)", b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input int gap);
        foreach (stream[i]) begin
            if (gap > 0 && i > 0) idle(gap);
            send_byte(stream[i]);
        end
    endtask

    task automatic check_end(input string tag, input logic exp_done, input logic exp_err,
                             input logic [15:0] exp_words, input int wr_base, input int exp_wr);
        @(negedge clk);
        check({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
        check({tag, "_error"}, {31'h0, error}, {31'h0, exp_err});
        check({tag, "_cpu_reset"}, {31'h0, cpu_reset}, {31'h0, !exp_done});
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_in_ready"}, {31'h0, bus.in_ready}, 32'h0);
        check({tag, "_words"}, {16'h0, words_loaded}, {16'h0, exp_words});
        check({tag, "_wr_count"}, wr_count - wr_base, exp_wr);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    int base;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
        check("rst_we", {31'h0, bus.imem_we}, 32'h0);
        check("rst_done_err", {30'h0, done, error}, 32'h0);
        check("rst_addr", {16'h0, bus.imem_addr}, 32'h0);
        check("rst_words", {16'h0, words_loaded}, 32'h0);
        reset = 1'b0;

        // Nominal load, back-to-back bytes.
        base = wr_count;
        expect_wr(16'h0000, 16'h1234);
        expect_wr(16'h0002, 16'hABCD);
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        pulse_start();
        send_stream(0);
        check_end("nominal", 1'b1, 1'b0, 16'd2, base, 2);

        // Restart from DONE, then the same load with 3-cycle gaps and a stray start.
        pulse_start();
        check("restart_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("restart_done", {31'h0, done}, 32'h0);
        check("restart_busy", {31'h0, busy}, 32'h1);
        base = wr_count;
        expect_wr(16'h0000, 16'h1234);
        expect_wr(16'h0002, 16'hABCD);
        stream = '{8'h00, 8'h02, 8'h12};
        send_stream(3);
        pulse_start();
        check("ignored_start_busy", {31'h0, busy}, 32'h1);
        stream = '{8'h34, 8'hAB, 8'hCD, 8'h42};
        send_stream(3);
        check_end("gapped", 1'b1, 1'b0, 16'd2, base, 2);

        // Empty load.
        base = wr_count;
        stream = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_stream(0);
        check_end("empty", 1'b1, 1'b0, 16'd0, base, 0);

        // Oversize: N = 257, rejected straight after LEN_LO.
        base = wr_count;
        stream = '{8'h01, 8'h01};
        pulse_start();
        send_stream(0);
        check_end("oversize", 1'b0, 1'b1, 16'd0, base, 0);

        // Bad checksum: correct CHK would be FE.
        base = wr_count;
        expect_wr(16'h0000, 16'h55AA);
        stream = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h00};
        pulse_start();
        send_stream(0);
        check_end("badchk", 1'b0, 1'b1, 16'd1, base, 1);

        // Asynchronous reset right after the first WRITE.
        base = wr_count;
        expect_wr(16'h0000, 16'h1234);
        stream = '{8'h00, 8'h02, 8'h12, 8'h34};
        pulse_start();
        send_stream(0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_wr_count", wr_count - base, 1);
        check("midrst_cpu_reset", {31'h0, cpu_reset}, 32'h1);
        check("midrst_busy_ready_we", {29'h0, busy, bus.in_ready, bus.imem_we}, 32'h0);
        check("midrst_done_err", {30'h0, done, error}, 32'h0);
        check("midrst_addr", {16'h0, bus.imem_addr}, 32'h0);
        check("midrst_wdata", {16'h0, bus.imem_wdata}, 32'h0);
        check("midrst_words", {16'h0, words_loaded}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // A full load after the aborted one succeeds.
        base = wr_count;
        expect_wr(16'h0000, 16'h1234);
        expect_wr(16'h0002, 16'hABCD);
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        pulse_start();
        send_stream(0);
        check_end("after_rst", 1'b1, 1'b0, 16'd2, base, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
